// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 load, per-round C/D rotation, PC-2 subkey with valid/ready.
// Define DES_KEY_PARITY_CHECK_EN to reject keys whose bytes fail odd parity (reported on key_err).
module des_key_schedule #(
    parameter int unsigned ROUNDS  = 16,
    parameter int unsigned OUT_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [64:1] key,
    input  logic        decrypt,
    output logic [48:1] subkey_out,
    output logic [3:0]  round_idx,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy,
    output logic        done,
    output logic        key_err
);

    // Bit n of every vector here is DES bit n; C is CD bits 1..28, D is CD bits 29..56.
    localparam int unsigned Pc1Tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int unsigned Pc2Tab [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [4:0] shift_of(input logic [4:0] n);
        return (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 5'd1 : 5'd2;
    endfunction

    function automatic logic [4:0] dec_load();
        int unsigned s;
        s = 0;
        for (int n = 1; n <= int'(ROUNDS); n++) s = s + 32'(shift_of(5'(n)));
        return 5'(s % 28);
    endfunction

    localparam logic [4:0] DecLoad = dec_load();
    localparam logic [3:0] LastIdx = 4'(ROUNDS - 1);

    function automatic logic [56:1] pc1(input logic [64:1] k);
        logic [56:1] r;
        for (int i = 0; i < 56; i++) r[i+1] = k[Pc1Tab[i][6:0]];
        return r;
    endfunction

    function automatic logic [48:1] pc2(input logic [56:1] cd);
        logic [48:1] r;
        for (int i = 0; i < 48; i++) r[i+1] = cd[Pc2Tab[i][5:0]];
        return r;
    endfunction

    // DES left rotation moves bit i+k into bit i, i.e. a vector right-rotate here.
    function automatic logic [28:1] rotl(input logic [28:1] x, input logic [4:0] k);
        return (x >> k) | (x << (5'd28 - k));
    endfunction

    function automatic logic [28:1] rotr(input logic [28:1] x, input logic [4:0] k);
        return rotl(x, 5'd28 - k);
    endfunction

    typedef enum logic [1:0] {StIdle, StGen, StFin} state_e;

    state_e      state_q;
    logic [28:1] c_q, d_q;
    logic [48:1] sub_q;
    logic [3:0]  idx_q;
    logic        dec_q, valid_q, busy_q, done_q;

    logic [56:1] cd_load;
    logic [28:1] c_ld, d_ld, c_rot, d_rot;
    logic [4:0]  ld_amt, hs_amt;
    logic        last, key_ok;

    always_comb begin
        cd_load = pc1(key);
        ld_amt  = decrypt ? DecLoad : 5'd1;
        c_ld    = rotl(cd_load[28:1], ld_amt);
        d_ld    = rotl(cd_load[56:29], ld_amt);
        // Encrypt steps to the next round's shift; decrypt undoes the current round's shift.
        hs_amt  = dec_q ? shift_of(5'(idx_q) + 5'd1) : shift_of(5'(idx_q) + 5'd2);
        c_rot   = dec_q ? rotr(c_q, hs_amt) : rotl(c_q, hs_amt);
        d_rot   = dec_q ? rotr(d_q, hs_amt) : rotl(d_q, hs_amt);
        last    = dec_q ? (idx_q == 4'd0) : (idx_q == LastIdx);
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic key_err_q;

    always_comb begin
        key_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!(^key[8*k+8 -: 8])) key_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_err_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            key_err_q <= !key_ok;
        end
    end

    assign key_err = key_err_q;
`else
    assign key_ok  = 1'b1;
    assign key_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            sub_q   <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && key_ok) begin
                        c_q     <= c_ld;
                        d_q     <= d_ld;
                        dec_q   <= decrypt;
                        idx_q   <= decrypt ? LastIdx : 4'd0;
                        valid_q <= (OUT_REG == 0);
                        busy_q  <= 1'b1;
                        state_q <= StGen;
                    end
                end
                StGen: begin
                    if (!valid_q) begin
                        // Output-register fill cycle after a load or a rotation.
                        sub_q   <= pc2({d_q, c_q});
                        valid_q <= 1'b1;
                    end else if (subkey_ready) begin
                        if (last) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            c_q     <= c_rot;
                            d_q     <= d_rot;
                            idx_q   <= dec_q ? idx_q - 4'd1 : idx_q + 4'd1;
                            valid_q <= (OUT_REG == 0);
                        end
                    end
                end
                StFin: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign subkey_out   = (OUT_REG != 0) ? sub_q : pc2({d_q, c_q});
    assign round_idx    = idx_q;
    assign subkey_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: table of full sequences plus reset, parity and ROUNDS=4 cases.
// Hex constants are written in DES order (DES bit 1 leftmost) and bit-reversed onto the [n:1] ports.
module tb_des_key_schedule;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, decrypt, subkey_ready;
    logic [64:1] key;
    logic [48:1] subkey_out;
    logic [3:0]  round_idx;
    logic        subkey_valid, busy, done, key_err;

    logic        start4, ready4;
    logic [48:1] sub4;
    logic [3:0]  idx4;
    logic        valid4, busy4, done4, err4;

    des_key_schedule #(.ROUNDS(16), .OUT_REG(1)) dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .decrypt(decrypt),
        .subkey_out(subkey_out), .round_idx(round_idx), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .busy(busy), .done(done), .key_err(key_err)
    );

    des_key_schedule #(.ROUNDS(4), .OUT_REG(1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .key(key), .decrypt(decrypt),
        .subkey_out(sub4), .round_idx(idx4), .subkey_valid(valid4),
        .subkey_ready(ready4), .busy(busy4), .done(done4), .key_err(err4)
    );

    localparam logic [63:0] StdKey = 64'h133457799BBCDFF1;

    int n_vec = 0;
    int n_err = 0;
    logic [47:0] ksched [16];

    typedef struct {
        string       nm;
        logic [63:0] key;
        logic        dec;
        int          stall_at;
        int          stall_len;
        logic        use_tab;
    } vec_t;
    vec_t vecs [4];

    function automatic logic [64:1] to_key(input logic [63:0] h);
        logic [64:1] r;
        for (int i = 0; i < 64; i++) r[i+1] = h[63-i];
        return r;
    endfunction

    function automatic logic [48:1] to_sk(input logic [47:0] h);
        logic [48:1] r;
        for (int i = 0; i < 48; i++) r[i+1] = h[47-i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string nm, input logic [63:0] kh, input logic dec,
                           input int stall_at, input int stall_len, input logic use_tab);
        logic [48:1] exp_sk;
        logic [3:0]  exp_idx;
        int          w;
        key = to_key(kh); decrypt = dec; start = 1'b1; subkey_ready = 1'b1;
        tick();
        // start stays high with a different key/mode: both must be ignored while busy
        key = to_key(64'h0123456789ABCDEF); decrypt = ~dec;
        chk({nm, " busy_after_start"}, 64'(busy), 64'd1);
        chk({nm, " valid_lat0"}, 64'(subkey_valid), 64'd0);
        tick();
        chk({nm, " valid_lat1"}, 64'(subkey_valid), 64'd1);
        for (int n = 0; n < 16; n++) begin
            w = 0;
            while (!subkey_valid && w < 4) begin tick(); w++; end
            exp_idx = dec ? 4'(15 - n) : 4'(n);
            exp_sk  = use_tab ? to_sk(ksched[exp_idx]) : '0;
            chk({nm, " valid"}, 64'(subkey_valid), 64'd1);
            chk({nm, " subkey"}, 64'(subkey_out), 64'(exp_sk));
            chk({nm, " round_idx"}, 64'(round_idx), 64'(exp_idx));
            chk({nm, " early_done"}, 64'(done), 64'd0);
            if (n == stall_at) begin
                subkey_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk({nm, " stall_valid"}, 64'(subkey_valid), 64'd1);
                    chk({nm, " stall_subkey"}, 64'(subkey_out), 64'(exp_sk));
                    chk({nm, " stall_idx"}, 64'(round_idx), 64'(exp_idx));
                end
                subkey_ready = 1'b1;
            end
            tick();
            if (n < 15) chk({nm, " gap_valid"}, 64'(subkey_valid), 64'd0);
        end
        chk({nm, " done"}, 64'(done), 64'd1);
        chk({nm, " fin_valid"}, 64'(subkey_valid), 64'd0);
        chk({nm, " fin_busy"}, 64'(busy), 64'd1);
        start = 1'b0;
        tick();
        chk({nm, " done_pulse"}, 64'(done), 64'd0);
        chk({nm, " idle_busy"}, 64'(busy), 64'd0);
        tick();
        chk({nm, " no_restart"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        ksched = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                   48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                   48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                   48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        vecs[0] = '{"enc",       StdKey, 1'b0, -1, 0, 1'b1};
        vecs[1] = '{"dec",       StdKey, 1'b1, -1, 0, 1'b1};
        vecs[2] = '{"enc_stall", StdKey, 1'b0,  2, 5, 1'b1};
        vecs[3] = '{"dec_stall", StdKey, 1'b1,  9, 3, 1'b1};

        rst = 1'b0; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1; key = '0;
        start4 = 1'b0; ready4 = 1'b1;
        tick(); tick();
        chk("reset subkey", 64'(subkey_out), 64'd0);
        chk("reset idx", 64'(round_idx), 64'd0);
        chk("reset valid", 64'(subkey_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset key_err", 64'(key_err), 64'd0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_seq(vecs[v].nm, vecs[v].key, vecs[v].dec, vecs[v].stall_at,
                    vecs[v].stall_len, vecs[v].use_tab);
        end

        // Reset in the middle of a sequence
        key = to_key(StdKey); decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!(subkey_valid && round_idx == 4'd6) && w < 40) begin
            tick(); w++;
            chk("midrst early_done", 64'(done), 64'd0);
        end
        chk("midrst reached_round7", 64'(subkey_valid && round_idx == 4'd6), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst subkey", 64'(subkey_out), 64'd0);
        chk("midrst idx", 64'(round_idx), 64'd0);
        chk("midrst valid", 64'(subkey_valid), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst done", 64'(done), 64'd0);
        tick(); tick();
        chk("midrst held_busy", 64'(busy), 64'd0);
        chk("midrst held_valid", 64'(subkey_valid), 64'd0);
        rst = 1'b1;
        tick();
        chk("postrst done", 64'(done), 64'd0);
        chk("postrst busy", 64'(busy), 64'd0);
        run_seq("after_rst", StdKey, 1'b0, -1, 0, 1'b1);

`ifdef DES_KEY_PARITY_CHECK_EN
        key = '0; decrypt = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("parity key_err", 64'(key_err), 64'd1);
        chk("parity busy", 64'(busy), 64'd0);
        tick(); tick();
        chk("parity sticky", 64'(key_err), 64'd1);
        chk("parity no_valid", 64'(subkey_valid), 64'd0);
        chk("parity still_idle", 64'(busy), 64'd0);
        key = to_key(StdKey); start = 1'b1;
        tick();
        start = 1'b0;
        chk("parity cleared", 64'(key_err), 64'd0);
        chk("parity good_busy", 64'(busy), 64'd1);
        w = 0;
        while (!done && w < 60) begin tick(); w++; end
        chk("parity good_done", 64'(done), 64'd1);
        tick();
`else
        run_seq("zero_key", 64'h0, 1'b0, -1, 0, 1'b0);
        chk("zero_key key_err", 64'(key_err), 64'd0);
`endif

        // ROUNDS=4 decrypt: K4..K1 with indices 3..0
        key = to_key(StdKey); decrypt = 1'b1; start4 = 1'b1; ready4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            w = 0;
            while (!valid4 && w < 4) begin tick(); w++; end
            chk("r4 valid", 64'(valid4), 64'd1);
            chk("r4 subkey", 64'(sub4), 64'(to_sk(ksched[3-n])));
            chk("r4 idx", 64'(idx4), 64'(3 - n));
            chk("r4 early_done", 64'(done4), 64'd0);
            tick();
        end
        chk("r4 done", 64'(done4), 64'd1);
        chk("r4 no_fifth", 64'(valid4), 64'd0);
        tick();
        chk("r4 done_pulse", 64'(done4), 64'd0);
        chk("r4 idle", 64'(busy4), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, legal range 1..16: the number of subkeys emitted per key.
REQ-002 SHALL have parameter OUT_REG, default 1: 1 registers subkey_out, 0 drives it combinationally from the C/D registers; latency figures below are for OUT_REG=1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: load request, sampled only in IDLE.
REQ-006 SHALL have port key, input, 64 bits [64:1]: DES key, where key[n] is DES bit n.
REQ-007 SHALL have port decrypt, input, 1 bit: mode sampled with start (0 = K1 first, 1 = K_ROUNDS first).
REQ-008 SHALL have port subkey_out, output, 48 bits [48:1]: PC-2 subkey of the current round.
REQ-009 SHALL have port round_idx, output, 4 bits: round number minus 1 of subkey_out.
REQ-010 SHALL have port subkey_valid, output, 1 bit: subkey_out/round_idx are valid.
REQ-011 SHALL have port subkey_ready, input, 1 bit: consumer accepts the subkey.
REQ-012 SHALL have port busy, output, 1 bit: high outside IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last subkey is accepted.
REQ-014 SHALL have port key_err, output, 1 bit: parity failure flag (see Configuration).

Function
REQ-015 SHALL implement states IDLE, GEN, FIN; IDLE->GEN on start (key accepted); GEN->FIN on handshake of the last subkey; FIN->IDLE after one cycle with done=1.
REQ-016 On key acceptance SHALL apply PC-1 to key into 28-bit registers C,D; encrypt: rotate left by shift[1]; decrypt: rotate left by the sum of shift[1..ROUNDS] mod 28; shift table = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-017 subkey_out SHALL equal PC-2 of {C,D}, with bit numbering identical to the team's existing PC-2 mapping (out bit 1 = CD bit 14 ... out bit 48 = CD bit 32).
REQ-018 start accepted at edge t SHALL give subkey_valid=1 with the first subkey after edge t+1; a handshake is subkey_valid && subkey_ready at an edge.
REQ-019 subkey_out and round_idx SHALL hold stable while subkey_valid=1 and subkey_ready=0.
REQ-020 On a handshake of round r: encrypt SHALL rotate C,D left by shift[r+1]; decrypt SHALL rotate C,D right by shift[r]; the next subkey is valid on the following cycle (one subkey per two cycles at most when OUT_REG=1, one per cycle when OUT_REG=0).
REQ-021 round_idx SHALL count 0..ROUNDS-1 in encrypt mode and ROUNDS-1..0 in decrypt mode.
REQ-022 start, key and decrypt SHALL be ignored while busy=1, including the cycle of the final handshake.
REQ-023 Changes to decrypt after acceptance SHALL have no effect until the next start.

Reset
REQ-024 When rst=0, the block SHALL asynchronously enter IDLE and set C, D, subkey_out, round_idx, subkey_valid, busy, done and key_err to 0.
REQ-025 Reset asserted mid-generation SHALL abandon the sequence with no done pulse; the first start after rst rises begins a fresh sequence.

Configuration
REQ-026 Macro DES_KEY_PARITY_CHECK_EN defined: at start, each key byte (bits 8k-7..8k) SHALL be checked for odd parity; on any failure the block SHALL stay in IDLE, set key_err=1 (sticky until the next start with a passing key or reset) and emit no subkeys and no done pulse.
REQ-027 Macro not defined: key_err SHALL be tied to 0 and parity bits SHALL be ignored.

Verification
REQ-028 Key 133457799BBCDFF1, decrypt=0, ready=1 -> first subkey 1B02EFFC7072 with round_idx=0, and the 16th subkey CB3D8B0E17F5 with round_idx=15, followed by a done pulse.
REQ-029 Same key, decrypt=1 -> first subkey CB3D8B0E17F5 with round_idx=15, last subkey 1B02EFFC7072 with round_idx=0.
REQ-030 subkey_ready held at 0 for 5 cycles on round 3 -> subkey_out and round_idx stay constant, with no skipped or repeated rounds afterwards.
REQ-031 rst pulsed low at round 7, then a new start -> all outputs 0 during reset, then a full sequence from round_idx 0 with no spurious done.
REQ-032 With DES_KEY_PARITY_CHECK_EN defined, key 0000000000000000 -> key_err=1, busy remains 0, no subkey_valid; without the macro the same key -> 16 subkeys and done.
REQ-033 ROUNDS=4, decrypt=1 -> exactly 4 subkeys with round_idx 3,2,1,0, each matching the corresponding ROUNDS=16 encrypt value.
